bus_fabric: RTL and testbench

//   Parametrised shared-bus interconnect for the CPU datapath. It generalises the fixed 4-source

---
 rtl/bus_fabric.sv | 123 ++++++++++++
 tb/tb_bus_fabric.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_fabric.sv
// Parametrised priority shared bus with an optional pipeline stage, display latch
// and sticky contention tracking (flag, saturating counter, conflicting-enable snapshot).
module bus_fabric #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned NSRC       = 4,
    parameter int unsigned REGISTERED = 0,
    parameter int unsigned DISP_W     = 8,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NSRC-1:0]         src_en,
    input  logic [NSRC*WIDTH-1:0]   src_data,
    input  logic                    disp_capture,
    input  logic                    clr_err,
    output logic [WIDTH-1:0]        bus,
    output logic                    bus_valid,
    output logic [NSRC-1:0]         grant,
    output logic [DISP_W-1:0]       disp_out,
    output logic                    disp_valid,
    output logic                    contention,
    output logic [CNT_W-1:0]        contention_cnt,
    output logic [NSRC-1:0]         last_conflict
);

    logic [WIDTH-1:0]  bus_c;
    logic [NSRC-1:0]   grant_c;
    logic              bus_valid_c;
    logic              multi_c;
    logic              found;

    logic [DISP_W-1:0] disp_q, disp_d;
    logic              disp_valid_q, disp_valid_d;
    logic              contention_q, contention_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NSRC-1:0]   last_q, last_d;

    // Lowest asserted enable index wins the bus.
    always_comb begin
        bus_c   = '0;
        grant_c = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (src_en[i] && !found) begin
                found      = 1'b1;
                grant_c[i] = 1'b1;
                bus_c      = src_data[i*WIDTH +: WIDTH];
            end
        end
        bus_valid_c = |src_en;
    end

    // Two or more enables: clearing the lowest set bit leaves something behind.
    assign multi_c = (src_en & (src_en - NSRC'(1))) != '0;

    if (REGISTERED != 0) begin : g_reg
        logic [WIDTH-1:0] bus_q;
        logic [NSRC-1:0]  grant_q;
        logic             bus_valid_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                bus_q       <= '0;
                grant_q     <= '0;
                bus_valid_q <= 1'b0;
            end else begin
                bus_q       <= bus_c;
                grant_q     <= grant_c;
                bus_valid_q <= bus_valid_c;
            end
        end

        assign bus       = bus_q;
        assign grant     = grant_q;
        assign bus_valid = bus_valid_q;
    end else begin : g_comb
        assign bus       = bus_c;
        assign grant     = grant_c;
        assign bus_valid = bus_valid_c;
    end

    // Clear is applied first so a contending cycle under clr_err restarts the count at 1.
    always_comb begin
        disp_d       = disp_capture ? bus[DISP_W-1:0] : disp_q;
        disp_valid_d = disp_valid_q | disp_capture;
        contention_d = contention_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        if (clr_err) begin
            contention_d = 1'b0;
            cnt_d        = '0;
            last_d       = '0;
        end
        if (multi_c) begin
            contention_d = 1'b1;
            last_d       = src_en;
            cnt_d        = (&cnt_d) ? cnt_d : cnt_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_q       <= '0;
            disp_valid_q <= 1'b0;
            contention_q <= 1'b0;
            cnt_q        <= '0;
            last_q       <= '0;
        end else begin
            disp_q       <= disp_d;
            disp_valid_q <= disp_valid_d;
            contention_q <= contention_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
        end
    end

    assign disp_out       = disp_q;
    assign disp_valid     = disp_valid_q;
    assign contention     = contention_q;
    assign contention_cnt = cnt_q;
    assign last_conflict  = last_q;

endmodule

// File: tb/tb_bus_fabric.sv
// Directed bench for bus_fabric: combinational, pipelined, narrow-counter and
// single-source instances driven from shared stimulus.
module tb_bus_fabric;

    logic        clk;
    logic        rst;
    logic [3:0]  src_en;
    logic [63:0] src_data;
    logic        disp_capture;
    logic        clr_err;
    logic        s1_en;
    logic [15:0] s1_data;

    int unsigned errors;
    int unsigned checks;

    logic [15:0] d0_bus, d1_bus, d2_bus, d3_bus;
    logic        d0_bv, d1_bv, d2_bv, d3_bv;
    logic [3:0]  d0_gnt, d1_gnt, d2_gnt;
    logic [0:0]  d3_gnt;
    logic [7:0]  d0_disp, d1_disp, d2_disp, d3_disp;
    logic        d0_dv, d1_dv, d2_dv, d3_dv;
    logic        d0_con, d1_con, d2_con, d3_con;
    logic [7:0]  d0_cnt, d1_cnt, d3_cnt;
    logic [1:0]  d2_cnt;
    logic [3:0]  d0_last, d1_last, d2_last;
    logic [0:0]  d3_last;

    bus_fabric #(.WIDTH(16), .NSRC(4), .REGISTERED(0), .DISP_W(8), .CNT_W(8)) u_d0 (
        .clk(clk), .rst(rst), .src_en(src_en), .src_data(src_data),
        .disp_capture(disp_capture), .clr_err(clr_err),
        .bus(d0_bus), .bus_valid(d0_bv), .grant(d0_gnt), .disp_out(d0_disp),
        .disp_valid(d0_dv), .contention(d0_con), .contention_cnt(d0_cnt),
        .last_conflict(d0_last));

    bus_fabric #(.WIDTH(16), .NSRC(4), .REGISTERED(1), .DISP_W(8), .CNT_W(8)) u_d1 (
        .clk(clk), .rst(rst), .src_en(src_en), .src_data(src_data),
        .disp_capture(disp_capture), .clr_err(clr_err),
        .bus(d1_bus), .bus_valid(d1_bv), .grant(d1_gnt), .disp_out(d1_disp),
        .disp_valid(d1_dv), .contention(d1_con), .contention_cnt(d1_cnt),
        .last_conflict(d1_last));

    bus_fabric #(.WIDTH(16), .NSRC(4), .REGISTERED(0), .DISP_W(8), .CNT_W(2)) u_d2 (
        .clk(clk), .rst(rst), .src_en(src_en), .src_data(src_data),
        .disp_capture(disp_capture), .clr_err(clr_err),
        .bus(d2_bus), .bus_valid(d2_bv), .grant(d2_gnt), .disp_out(d2_disp),
        .disp_valid(d2_dv), .contention(d2_con), .contention_cnt(d2_cnt),
        .last_conflict(d2_last));

    bus_fabric #(.WIDTH(16), .NSRC(1), .REGISTERED(0), .DISP_W(8), .CNT_W(8)) u_d3 (
        .clk(clk), .rst(rst), .src_en(s1_en), .src_data(s1_data),
        .disp_capture(disp_capture), .clr_err(clr_err),
        .bus(d3_bus), .bus_valid(d3_bv), .grant(d3_gnt), .disp_out(d3_disp),
        .disp_valid(d3_dv), .contention(d3_con), .contention_cnt(d3_cnt),
        .last_conflict(d3_last));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        rst          = 1'b1;
        src_en       = '0;
        src_data     = '0;
        disp_capture = 1'b0;
        clr_err      = 1'b0;
        s1_en        = 1'b0;
        s1_data      = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Reset state
        chk("rst_d0_con",  32'(d0_con),  32'h0);
        chk("rst_d0_cnt",  32'(d0_cnt),  32'h0);
        chk("rst_d0_last", 32'(d0_last), 32'h0);
        chk("rst_d0_dv",   32'(d0_dv),   32'h0);
        chk("rst_d1_bus",  32'(d1_bus),  32'h0);
        chk("rst_d1_bv",   32'(d1_bv),   32'h0);
        chk("idle_d0_gnt", 32'(d0_gnt),  32'h0);

        // Single source, same-cycle resolution
        src_en = 4'b0100;
        src_data[2*16 +: 16] = 16'hBEEF;
        #1;
        chk("t1_d0_bus", 32'(d0_bus), 32'hBEEF);
        chk("t1_d0_gnt", 32'(d0_gnt), 32'h4);
        chk("t1_d0_bv",  32'(d0_bv),  32'h1);
        chk("t1_d0_con", 32'(d0_con), 32'h0);
        chk("t1_d1_bus_pre", 32'(d1_bus), 32'h0);
        tick();
        chk("t1_d1_bus", 32'(d1_bus), 32'hBEEF);
        chk("t1_d1_gnt", 32'(d1_gnt), 32'h4);
        chk("t1_d0_con_after", 32'(d0_con), 32'h0);

        // Two sources: priority winner drives, contention recorded next edge
        src_en = 4'b0110;
        src_data[1*16 +: 16] = 16'h1234;
        src_data[2*16 +: 16] = 16'h5678;
        #1;
        chk("t2_d0_bus", 32'(d0_bus), 32'h1234);
        chk("t2_d0_gnt", 32'(d0_gnt), 32'h2);
        chk("t2_d0_con_pre", 32'(d0_con), 32'h0);
        tick();
        src_en = 4'b0000;
        chk("t2_d0_con",  32'(d0_con),  32'h1);
        chk("t2_d0_cnt",  32'(d0_cnt),  32'h1);
        chk("t2_d0_last", 32'(d0_last), 32'h6);
        chk("t2_d1_bus",  32'(d1_bus),  32'h1234);
        chk("t2_d1_gnt",  32'(d1_gnt),  32'h2);
        tick();
        chk("t2_d1_bv_idle", 32'(d1_bv), 32'h0);
        chk("t2_d0_con_sticky", 32'(d0_con), 32'h1);

        // Clear without contention
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_d0_con",  32'(d0_con),  32'h0);
        chk("clr_d0_cnt",  32'(d0_cnt),  32'h0);
        chk("clr_d0_last", 32'(d0_last), 32'h0);

        // Saturation on a 2-bit counter: 1,2,3,3,3
        src_en = 4'b0110;
        tick(); chk("t3_cnt1", 32'(d2_cnt), 32'h1);
        tick(); chk("t3_cnt2", 32'(d2_cnt), 32'h2);
        tick(); chk("t3_cnt3", 32'(d2_cnt), 32'h3);
        tick(); chk("t3_cnt4", 32'(d2_cnt), 32'h3);
        tick(); chk("t3_cnt5", 32'(d2_cnt), 32'h3);
        chk("t3_d0_cnt5", 32'(d0_cnt), 32'h5);

        // Clear and new contention in the same cycle
        src_en  = 4'b0011;
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        src_en  = 4'b0000;
        chk("t3_clr_cnt",  32'(d2_cnt),  32'h1);
        chk("t3_clr_con",  32'(d2_con),  32'h1);
        chk("t3_clr_last", 32'(d2_last), 32'h3);
        chk("t3_clr_d0_cnt", 32'(d0_cnt), 32'h1);

        // Pipelined bus and display capture of the registered value
        src_data[0*16 +: 16] = 16'h00A5;
        src_en = 4'b0001;
        tick();
        src_en = 4'b0000;
        disp_capture = 1'b1;
        chk("t4_d1_bus", 32'(d1_bus), 32'h00A5);
        chk("t4_d1_gnt", 32'(d1_gnt), 32'h1);
        chk("t4_d1_bv",  32'(d1_bv),  32'h1);
        tick();
        disp_capture = 1'b0;
        chk("t4_d1_disp", 32'(d1_disp), 32'hA5);
        chk("t4_d1_dv",   32'(d1_dv),   32'h1);
        chk("t4_d0_disp", 32'(d0_disp), 32'h00);
        chk("t4_d0_dv",   32'(d0_dv),   32'h1);
        src_en = 4'b1000;
        src_data[3*16 +: 16] = 16'hCC3C;
        tick();
        chk("t4_d1_hold", 32'(d1_disp), 32'hA5);
        chk("t4_d0_hold", 32'(d0_disp), 32'h00);
        chk("t4_d0_dv_hold", 32'(d0_dv), 32'h1);
        chk("t4_d1_bus_src3", 32'(d1_bus), 32'hCC3C);

        // Single-source instance: grant mirrors enable, never contends
        s1_en   = 1'b1;
        s1_data = 16'h0F0F;
        #1;
        chk("n1_gnt", 32'(d3_gnt), 32'h1);
        chk("n1_bus", 32'(d3_bus), 32'h0F0F);
        tick();
        chk("n1_con", 32'(d3_con), 32'h0);
        chk("n1_cnt", 32'(d3_cnt), 32'h0);
        s1_en = 1'b0;
        #1;
        chk("n1_gnt_idle", 32'(d3_gnt), 32'h0);

        // Reset wins over capture and contention, and flushes the pipeline
        src_en       = 4'b0110;
        disp_capture = 1'b1;
        rst          = 1'b1;
        tick();
        rst          = 1'b0;
        disp_capture = 1'b0;
        src_en       = 4'b0000;
        #1;
        chk("t5_d0_con",  32'(d0_con),  32'h0);
        chk("t5_d0_cnt",  32'(d0_cnt),  32'h0);
        chk("t5_d0_last", 32'(d0_last), 32'h0);
        chk("t5_d0_dv",   32'(d0_dv),   32'h0);
        chk("t5_d1_disp", 32'(d1_disp), 32'h0);
        chk("t5_d1_dv",   32'(d1_dv),   32'h0);
        chk("t5_d1_bus",  32'(d1_bus),  32'h0);
        chk("t5_d1_gnt",  32'(d1_gnt),  32'h0);
        chk("t5_d1_bv",   32'(d1_bv),   32'h0);
        chk("t5_d0_bus",  32'(d0_bus),  32'h0);
        chk("t5_d0_gnt",  32'(d0_gnt),  32'h0);
        chk("t5_d2_cnt",  32'(d2_cnt),  32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
